// File: rtl/pipelined_core_fwd.sv
// pipelined_core_fwd: 4-stage IF/ID/EX/WB core with forwarding,
// BEQ flush, HALT drain, run/freeze, retire counter, debug read.
module pipelined_core_fwd #(
  parameter int          XLEN       = 32,
  parameter int          IMEM_WORDS = 256,
  parameter int          DMEM_WORDS = 256,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          run,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_WORDS)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  output logic [XLEN-1:0]               pc_out,
  output logic                          wb_valid,
  output logic [4:0]                    wb_rd,
  output logic [XLEN-1:0]               wb_data,
  output logic                          halted,
  output logic [31:0]                   retired_count,
  input  logic [4:0]                    dbg_raddr,
  output logic [XLEN-1:0]               dbg_rdata
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);
  localparam logic [31:0] HALT_INS = 32'h0000_0073;

  typedef enum logic [3:0] {
    K_NOP, K_ADD, K_SUB, K_AND, K_OR, K_XOR,
    K_ADDI, K_LW, K_SW, K_BEQ, K_HALT
  } kind_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [31:0]     ins;
  } if_id_t;

  typedef struct packed {
    logic            valid;
    kind_t           kind;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rv1;
    logic [XLEN-1:0] rv2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
  } id_ex_t;

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            halt;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ex_wb_t;

  logic [31:0]     imem [IMEM_WORDS];
  logic [XLEN-1:0] dmem [DMEM_WORDS];
  logic [XLEN-1:0] rf   [32];

  logic [XLEN-1:0] pc, pc_nxt;
  if_id_t          ifid, ifid_nxt;
  id_ex_t          idex, dec, idex_nxt;
  ex_wb_t          exwb, exwb_nxt;
  logic            halting;
  logic            id_halt;
  logic            taken;

  logic [6:0]      op;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [31:0]     ins;

  logic            wb_we;
  logic [XLEN-1:0] a, b, addr, res;
  logic [DAW-1:0]  didx;
  logic            rw;

  assign wb_we = exwb.valid && exwb.reg_write
              && (exwb.rd != 5'd0);

  // Decode IF/ID and read operands with write-through from EX/WB
  always_comb begin
    ins = ifid.ins;
    op  = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    dec = '0;
    dec.valid = ifid.valid;
    dec.pc    = ifid.pc;
    dec.rs1   = ins[19:15];
    dec.rs2   = ins[24:20];
    dec.rd    = ins[11:7];
    dec.kind  = K_NOP;
    unique case (1'b1)
      ins == HALT_INS:
        dec.kind = K_HALT;
      op == 7'h33 && f3 == 3'd0 && f7 == 7'h00:
        dec.kind = K_ADD;
      op == 7'h33 && f3 == 3'd0 && f7 == 7'h20:
        dec.kind = K_SUB;
      op == 7'h33 && f3 == 3'd7 && f7 == 7'h00:
        dec.kind = K_AND;
      op == 7'h33 && f3 == 3'd6 && f7 == 7'h00:
        dec.kind = K_OR;
      op == 7'h33 && f3 == 3'd4 && f7 == 7'h00:
        dec.kind = K_XOR;
      op == 7'h13 && f3 == 3'd0:
        dec.kind = K_ADDI;
      op == 7'h03 && f3 == 3'd2:
        dec.kind = K_LW;
      op == 7'h23 && f3 == 3'd2:
        dec.kind = K_SW;
      op == 7'h63 && f3 == 3'd0:
        dec.kind = K_BEQ;
      default:
        dec.kind = K_NOP;
    endcase
    unique case (dec.kind)
      K_SW:
        dec.imm = {{(XLEN-12){ins[31]}},
                   ins[31:25], ins[11:7]};
      K_BEQ:
        dec.imm = {{(XLEN-12){ins[31]}},
                   ins[7], ins[30:25],
                   ins[11:8], 1'b0};
      default:
        dec.imm = {{(XLEN-12){ins[31]}},
                   ins[31:20]};
    endcase
    if (wb_we && exwb.rd == dec.rs1)
      dec.rv1 = exwb.data;
    else
      dec.rv1 = rf[dec.rs1];
    if (wb_we && exwb.rd == dec.rs2)
      dec.rv2 = exwb.data;
    else
      dec.rv2 = rf[dec.rs2];
  end

  // Execute: forwarded operands, ALU, dmem read, branch resolve
  always_comb begin
    a = idex.rv1;
    b = idex.rv2;
    if (wb_we && exwb.rd == idex.rs1)
      a = exwb.data;
    if (wb_we && exwb.rd == idex.rs2)
      b = exwb.data;
    addr = a + idex.imm;
    didx = addr[DAW+1:2];
    res  = '0;
    rw   = 1'b0;
    unique case (idex.kind)
      K_ADD:  begin res = a + b; rw = 1'b1; end
      K_SUB:  begin res = a - b; rw = 1'b1; end
      K_AND:  begin res = a & b; rw = 1'b1; end
      K_OR:   begin res = a | b; rw = 1'b1; end
      K_XOR:  begin res = a ^ b; rw = 1'b1; end
      K_ADDI: begin res = addr;  rw = 1'b1; end
      K_LW:   begin res = dmem[didx]; rw = 1'b1; end
      K_SW:   res = addr;
      default: res = '0;
    endcase
    taken = idex.valid && idex.kind == K_BEQ
         && a == b;
    exwb_nxt = '0;
    if (idex.valid) begin
      exwb_nxt.valid     = 1'b1;
      exwb_nxt.reg_write = rw;
      exwb_nxt.halt      = idex.kind == K_HALT;
      exwb_nxt.rd        = rw ? idex.rd : 5'd0;
      exwb_nxt.data      = res;
    end
  end

  // Next fetch PC and IF/ID, ID/EX contents (flush beats halt)
  always_comb begin
    id_halt = ifid.valid && ifid.ins == HALT_INS;
    pc_nxt  = pc + XLEN'(4);
    ifid_nxt.valid = 1'b1;
    ifid_nxt.pc    = pc;
    ifid_nxt.ins   = imem[pc[IAW+1:2]];
    idex_nxt = dec;
    if (taken) begin
      pc_nxt   = idex.pc + idex.imm;
      ifid_nxt = '0;
      idex_nxt = '0;
    end else if (halting || id_halt) begin
      pc_nxt   = pc;
      ifid_nxt = '0;
    end
  end

  // Pipeline, PC and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= XLEN'(RESET_PC);
      ifid          <= '0;
      idex          <= '0;
      exwb          <= '0;
      halting       <= 1'b0;
      halted        <= 1'b0;
      retired_count <= '0;
    end else if (run) begin
      pc      <= pc_nxt;
      ifid    <= ifid_nxt;
      idex    <= idex_nxt;
      exwb    <= exwb_nxt;
      halting <= halting | (id_halt & ~taken);
      halted  <= halted | (exwb.valid & exwb.halt);
      retired_count <= retired_count
                     + {31'd0, exwb.valid};
    end
  end

  // Register file: cleared on reset, written from EX/WB
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++)
        rf[i] <= '0;
    end else if (run && wb_we) begin
      rf[exwb.rd] <= exwb.data;
    end
  end

  // Data memory store at the end of EX
  always_ff @(posedge clk) begin
    if (!rst && run && idex.valid
        && idex.kind == K_SW)
      dmem[didx] <= b;
  end

  // Instruction memory load port, independent of run/rst
  always_ff @(posedge clk) begin
    if (imem_we)
      imem[imem_waddr] <= imem_wdata;
  end

  assign pc_out    = pc;
  assign wb_valid  = exwb.valid;
  assign wb_rd     = exwb.rd;
  assign wb_data   = exwb.data;
  assign dbg_rdata = (dbg_raddr == 5'd0)
                   ? '0 : rf[dbg_raddr];

endmodule

// File: tb/tb_pipelined_core_fwd.sv
// tb_pipelined_core_fwd: directed programs on a 32-bit and a
// 16-bit core, checked with immediate assertions.
module tb_pipelined_core_fwd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b1;
  logic        imem_we = 1'b0;
  logic [7:0]  imem_waddr = '0;
  logic [31:0] imem_wdata = '0;
  logic [4:0]  dbg_raddr = '0;

  logic [31:0] pc_out, wb_data, dbg_rdata;
  logic        wb_valid, halted;
  logic [4:0]  wb_rd;
  logic [31:0] retired_count;

  logic [15:0] pc16, wbd16, dbg16;
  logic        wbv16, halted16;
  logic [4:0]  wbrd16;
  logic [31:0] ret16;

  int passed = 0;
  int total  = 0;
  logic [31:0] prog [8];

  pipelined_core_fwd dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .pc_out(pc_out),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .halted(halted),
    .retired_count(retired_count),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  pipelined_core_fwd #(.XLEN(16)) dut16 (
    .clk(clk), .rst(rst), .run(run),
    .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .pc_out(pc16),
    .wb_valid(wbv16), .wb_rd(wbrd16),
    .wb_data(wbd16), .halted(halted16),
    .retired_count(ret16),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg16)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic reg32(input string tag,
                       input logic [4:0] r,
                       input logic [63:0] exp);
    dbg_raddr = r;
    #1;
    chk(tag, {32'd0, dbg_rdata}, exp);
  endtask

  task automatic reg16(input string tag,
                       input logic [4:0] r,
                       input logic [63:0] exp);
    dbg_raddr = r;
    #1;
    chk(tag, {48'd0, dbg16}, exp);
  endtask

  task automatic load(input int n);
    rst = 1'b1;
    run = 1'b1;
    for (int i = 0; i < n; i++) begin
      imem_we    = 1'b1;
      imem_waddr = 8'(i);
      imem_wdata = prog[i];
      tick();
    end
    imem_we = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_halt(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (halted) break;
      tick();
    end
    chk(tag, {63'd0, halted}, 64'd1);
  endtask

  initial begin
    // 1: RAW chain
    prog = '{32'h00500093, 32'h00108133,
             32'h401101B3, 32'h00000073,
             32'h0, 32'h0, 32'h0, 32'h0};
    load(4);
    chk("rst_pc", pc_out, 0);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_ret", retired_count, 0);
    reg32("rst_x1", 1, 0);
    repeat (3) tick();
    chk("t1_wbv", wb_valid, 1);
    chk("t1_wbrd", wb_rd, 1);
    chk("t1_wbdata", wb_data, 5);
    chk("t1_pc", pc_out, 12);
    repeat (3) tick();
    chk("t1_not_yet", halted, 0);
    tick();
    chk("t1_halted", halted, 1);
    chk("t1_ret", retired_count, 4);
    chk("t1_pc_frozen", pc_out, 16);
    reg32("t1_x1", 1, 5);
    reg32("t1_x2", 2, 10);
    reg32("t1_x3", 3, 5);

    // 2: store then load-use
    prog = '{32'h07F00093, 32'h00102223,
             32'h00402103, 32'h001101B3,
             32'h00000073,
             32'h0, 32'h0, 32'h0};
    load(5);
    wait_halt("t2_halt");
    reg32("t2_x2", 2, 32'h7F);
    reg32("t2_x3", 3, 32'hFE);
    chk("t2_ret", retired_count, 5);

    // 3: taken branch skips two ADDIs
    prog = '{32'h00100093, 32'h00000663,
             32'h00900113, 32'h00900193,
             32'h00400213, 32'h00000073,
             32'h0, 32'h0};
    load(6);
    wait_halt("t3_halt");
    reg32("t3_x1", 1, 1);
    reg32("t3_x2", 2, 0);
    reg32("t3_x3", 3, 0);
    reg32("t3_x4", 4, 4);
    chk("t3_ret", retired_count, 4);

    // 4: HALT in the shadow of a taken branch
    prog = '{32'h00000463, 32'h00000073,
             32'h00700293, 32'h00000073,
             32'h0, 32'h0, 32'h0, 32'h0};
    load(4);
    wait_halt("t4_halt");
    reg32("t4_x5", 5, 7);
    chk("t4_ret", retired_count, 3);
    chk("t4_pc", pc_out, 16);

    // 5: x0 immunity, all-ones, dmem kept over reset
    prog = '{32'h00500013, 32'hFFF00313,
             32'h00402383, 32'h00000073,
             32'h0, 32'h0, 32'h0, 32'h0};
    load(4);
    wait_halt("t5_halt");
    reg32("t5_x0", 0, 0);
    reg32("t5_x6", 6, 32'hFFFFFFFF);
    reg32("t5_x7", 7, 32'h7F);
    reg16("t5_x6_16", 6, 16'hFFFF);
    reg16("t5_x7_16", 7, 16'h7F);
    chk("t5_halted16", halted16, 1);

    // 6a: freeze with run=0 mid-program
    prog = '{32'h00500093, 32'h00108133,
             32'h401101B3, 32'h00000073,
             32'h0, 32'h0, 32'h0, 32'h0};
    load(4);
    repeat (3) tick();
    run = 1'b0;
    repeat (5) tick();
    chk("t6_frz_pc", pc_out, 12);
    chk("t6_frz_ret", retired_count, 0);
    chk("t6_frz_wbd", wb_data, 5);
    reg32("t6_frz_x1", 1, 0);
    run = 1'b1;
    wait_halt("t6_halt_a");
    reg32("t6_a_x3", 3, 5);
    chk("t6_a_ret", retired_count, 4);

    // 6b: reset mid-program then rerun
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    reg32("t6_mid_x1", 1, 5);
    rst = 1'b1;
    tick();
    chk("t6_rst_pc", pc_out, 0);
    chk("t6_rst_ret", retired_count, 0);
    chk("t6_rst_wbv", wb_valid, 0);
    reg32("t6_rst_x1", 1, 0);
    reg32("t6_rst_x2", 2, 0);
    rst = 1'b0;
    wait_halt("t6_halt_b");
    reg32("t6_b_x2", 2, 10);
    reg32("t6_b_x3", 3, 5);
    chk("t6_b_ret", retired_count, 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
